int_trigger_gen: RTL and testbench
==================================

Name: int_trigger_gen

Overview:
Parametrised multi-channel external-interrupt stimulus generator for the CPU system bench and FPGA self-test harness. Each channel watches the macroscopic PC. On a programmed target-PC match it raises its interrupt line, up to a programmed number of times. Level-mode channels are cleared by a CPU store to their acknowledge word; pulse-mode channels clear themselves. A channel that is never acknowledged is flagged by a per-channel watchdog.

Parameters:
NCH, 4, number of independent interrupt channels (1..8)
ACK_BASE, 32'h0000_7f20, word address of the channel-0 acknowledge register; channel c acks at ACK_BASE + 4*c
CW, 4, width of the per-channel fire counter
TIMEOUT, 0, cycles a level-mode line may stay asserted before a watchdog error; 0 disables the watchdog

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
macroscopic_pc  in  32  architectural PC from the CPU; bits [1:0] ignored
m_int_addr  in  32  interrupt-bus store address; bits [1:0] ignored
m_int_byteen  in  4  interrupt-bus byte enables; any bit set means a store
cfg_we  in  1  configuration write strobe
cfg_ch  in  3  channel selected by cfg_we; values >= NCH are ignored
cfg_en  in  1  enable the selected channel
cfg_level  in  1  1 = level mode (hold until ack), 0 = one-cycle pulse
cfg_pc  in  32  target PC for the selected channel; bits [1:0] ignored
cfg_count  in  CW  number of fires; 0 = unlimited
irq  out  NCH  per-channel interrupt lines, registered
interrupt  out  1  OR of irq, combinational from registered irq
done  out  NCH  channel has exhausted its fire count, registered
timeout_err  out  NCH  sticky watchdog error, registered

Behaviour:
- Reset: all channels go to IDLE. irq, done, timeout_err = 0. Counters, guard bits, target PCs and modes are cleared.
- Match: pc_hit[c] = (macroscopic_pc & ~3) == (target_pc[c] & ~3).
- Ack: ack[c] = |m_int_byteen && (m_int_addr & ~3) == ACK_BASE + 4*c.
- Per-channel FSM states are IDLE, ARMED, ASSERT and DONE.
  - IDLE: irq = 0. Only a config write with cfg_en = 1 leaves IDLE, moving to ARMED.
  - ARMED: on pc_hit with guard clear, go to ASSERT and raise irq the next cycle (1-cycle latency from match). If cfg_count != 0, decrement remaining.
  - ASSERT, level mode: hold irq until ack. On ack, drop irq the next cycle. If remaining == 0 and the count is finite, go to DONE; otherwise go to ARMED.
  - ASSERT, pulse mode: irq is high for exactly one cycle, then the channel goes to ARMED or DONE by the same rule as level mode.
  - DONE: irq = 0 and done[c] = 1. Only a config write leaves DONE.
- Rearm guard: the guard is set on every entry to ASSERT. It clears on the first cycle with !pc_hit[c]. This prevents a refire while the CPU still sits at the target PC after the ack.
- Watchdog: applies to level mode only, with TIMEOUT > 0. A counter runs while in ASSERT. When it reaches TIMEOUT, timeout_err[c] is set (sticky until reset or config write), irq drops, and the channel goes to DONE.
- Config write: it loads target, mode and count, and clears guard, done, timeout_err and the watchdog counter. The channel then enters ARMED if cfg_en, else IDLE. Any in-progress assertion is aborted and irq drops the next cycle.
- Simultaneous events:
  - Config write beats match and ack on the same channel.
  - Ack beats watchdog expiry in the same cycle: no error is flagged.
  - Ack while not in ASSERT is ignored.
  - Ack and pc_hit in the same cycle in ASSERT: the ack is taken, and the guard still blocks an immediate refire.
- Channels are independent, and several may assert at once. interrupt is their OR.
- Counter width: remaining is CW bits and never underflows. The watchdog counter is sized $clog2(TIMEOUT+1).
- Reset mid-assertion: irq drops at that same clock edge, and all configuration is lost.

Decomposition:
- Package int_gen_pkg holds:
  - the state enum (IDLE, ARMED, ASSERT, DONE);
  - the mode constants MODE_PULSE = 0 and MODE_LEVEL = 1;
  - the ACK_STRIDE = 4 constant;
  - a helper that computes the ack address of a channel.
- Sub-module int_gen_channel holds one FSM, its counter, guard and watchdog. It is instantiated NCH times by a generate loop.
- The top module does config decode, ack decode and the OR reduction.

Test Plan:
- Single level fire: configure ch0 with pc = 0x3010, count = 1, level. Run the PC to 0x3010. Expect irq[0] = 1 one cycle after the match. Store to 0x7f20 with byteen = 4'hf. Expect irq[0] = 0 the next cycle and done[0] = 1. No second fire on a later 0x3010.
- Guard: count = 0 (unlimited), ack while the PC is held at 0x3010. Expect no refire. Move the PC to 0x3014 and back to 0x3010; expect a second fire.
- Pulse and multi-channel: ch1 in pulse mode at 0x3020 with count = 2, and ch2 in level mode at 0x3020. On a single match, expect irq[1] high for exactly one cycle, irq[2] held high, and interrupt high throughout. Ack at 0x7f28 clears ch2 only.
- Watchdog: TIMEOUT = 8, level fire, no ack. Expect timeout_err = 1 and irq = 0 exactly 8 cycles after the assertion. Then an ack with the expiry in the same cycle, on a fresh run, sets no error.
- Config preemption and reset: reconfigure a channel during ASSERT and expect irq to drop the next cycle with the channel ARMED on the new PC. Then assert reset during ASSERT on another channel; expect all outputs at 0 after that edge.

Source files
------------

// File: rtl/int_gen_pkg.sv
// Shared types and constants for the interrupt trigger generator.
// Holds the per-channel state enum, the mode encodings, the spacing
// between channel acknowledge words, and a helper that returns the
// acknowledge address of a given channel.
package int_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ASSERT = 2'd2,
    DONE   = 2'd3
  } chState_t;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  localparam int ACK_STRIDE = 4;

  // Word address of channel ch's acknowledge register.
  function automatic logic [31:0] ackAddr(input logic [31:0] base, input int ch);
    return {base[31:2], 2'b00} + 32'(ACK_STRIDE * ch);
  endfunction

endpackage

// File: rtl/int_gen_channel.sv
// One interrupt channel: the trigger FSM, its fire counter, the rearm
// guard and the level-mode watchdog.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   i_pc            CPU PC, word address bits only
//   i_ack           decoded store to this channel's acknowledge word
//   i_cfgWe         configuration write aimed at this channel
//   i_cfgEn         arm the channel on configuration
//   i_cfgLevel      1 = level mode, 0 = pulse mode
//   i_cfgPc         target PC, word address bits only
//   i_cfgCount      number of fires, 0 = unlimited
//   o_irq           registered interrupt line
//   o_done          registered "fire count exhausted"
//   o_timeoutErr    registered sticky watchdog error
module int_gen_channel
  import int_gen_pkg::*;
#(
  parameter int CW      = 4,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:2]   i_pc,
  input  logic          i_ack,
  input  logic          i_cfgWe,
  input  logic          i_cfgEn,
  input  logic          i_cfgLevel,
  input  logic [31:2]   i_cfgPc,
  input  logic [CW-1:0] i_cfgCount,
  output logic          o_irq,
  output logic          o_done,
  output logic          o_timeoutErr
);

  // A zero TIMEOUT still needs a legal one-bit counter; it is never used.
  localparam int WDW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIM);

  chState_t      r_state,      w_state;
  logic [31:2]   r_targetPc,   w_targetPc;
  logic          r_level,      w_level;
  logic          r_finite,     w_finite;
  logic [CW-1:0] r_remaining,  w_remaining;
  logic          r_guard,      w_guard;
  logic [WDW-1:0] r_wdCnt,     w_wdCnt;
  logic          r_timeoutErr, w_timeoutErr;
  logic          r_irq;
  logic          r_done;
  logic          w_pcHit;

  assign w_pcHit = (i_pc == r_targetPc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_targetPc   <= '0;
      r_level      <= MODE_PULSE;
      r_finite     <= 1'b0;
      r_remaining  <= '0;
      r_guard      <= 1'b0;
      r_wdCnt      <= '0;
      r_timeoutErr <= 1'b0;
      r_irq        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_targetPc   <= w_targetPc;
      r_level      <= w_level;
      r_finite     <= w_finite;
      r_remaining  <= w_remaining;
      r_guard      <= w_guard;
      r_wdCnt      <= w_wdCnt;
      r_timeoutErr <= w_timeoutErr;
      r_irq        <= (w_state == ASSERT);
      r_done       <= (w_state == DONE);
    end
  end

  // The guard only survives while the PC stays on the target; entering
  // ASSERT re-sets it so the CPU parked at the target cannot refire.
  // A configuration write overrides every other event this cycle, and
  // an ack beats a coincident watchdog expiry.
  always_comb begin
    w_state      = r_state;
    w_targetPc   = r_targetPc;
    w_level      = r_level;
    w_finite     = r_finite;
    w_remaining  = r_remaining;
    w_guard      = r_guard && w_pcHit;
    w_wdCnt      = r_wdCnt;
    w_timeoutErr = r_timeoutErr;
    if (i_cfgWe) begin
      w_targetPc   = i_cfgPc;
      w_level      = i_cfgLevel;
      w_finite     = (i_cfgCount != '0);
      w_remaining  = i_cfgCount;
      w_guard      = 1'b0;
      w_wdCnt      = '0;
      w_timeoutErr = 1'b0;
      w_state      = i_cfgEn ? ARMED : IDLE;
    end else begin
      case (r_state)
        ARMED: begin
          if (w_pcHit && !r_guard) begin
            w_state = ASSERT;
            w_guard = 1'b1;
            w_wdCnt = '0;
            if (r_finite && r_remaining != '0)
              w_remaining = r_remaining - 1'b1;
          end
        end
        ASSERT: begin
          if (r_level == MODE_PULSE || i_ack) begin
            w_state = (r_finite && r_remaining == '0) ? DONE : ARMED;
          end else if (TIMEOUT > 0) begin
            if (r_wdCnt == WD_LAST) begin
              w_timeoutErr = 1'b1;
              w_state      = DONE;
            end else begin
              w_wdCnt = r_wdCnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_irq        = r_irq;
  assign o_done       = r_done;
  assign o_timeoutErr = r_timeoutErr;

endmodule

// File: rtl/int_trigger_gen.sv
// Multi-channel external-interrupt stimulus generator. Decodes
// configuration writes and acknowledge stores, fans them out to NCH
// independent channels and ORs the channel lines into one interrupt.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   macroscopic_pc   architectural PC, bits [1:0] ignored
//   m_int_addr       interrupt-bus store address, bits [1:0] ignored
//   m_int_byteen     store byte enables, any set bit means a store
//   cfg_we/cfg_ch    configuration write strobe and target channel
//   cfg_en/level/pc/count  configuration payload
//   irq, done, timeout_err  per-channel registered status
//   interrupt        OR of irq
module int_trigger_gen
  import int_gen_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter logic [31:0] ACK_BASE = 32'h0000_7f20,
  parameter int          CW       = 4,
  parameter int          TIMEOUT  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    macroscopic_pc,
  input  logic [31:0]    m_int_addr,
  input  logic [3:0]     m_int_byteen,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_ch,
  input  logic           cfg_en,
  input  logic           cfg_level,
  input  logic [31:0]    cfg_pc,
  input  logic [CW-1:0]  cfg_count,
  output logic [NCH-1:0] irq,
  output logic           interrupt,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] timeout_err
);

  logic        w_store;
  logic [31:0] w_storeWord;
  logic        w_unusedBits;

  assign w_store      = |m_int_byteen;
  assign w_storeWord  = {m_int_addr[31:2], 2'b00};
  assign w_unusedBits = ^{macroscopic_pc[1:0], cfg_pc[1:0]};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic w_ack;
    logic w_cfgSel;

    assign w_ack    = w_store && (w_storeWord == ackAddr(ACK_BASE, c));
    assign w_cfgSel = cfg_we && (cfg_ch == 3'(c));

    int_gen_channel #(
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .i_pc         (macroscopic_pc[31:2]),
      .i_ack        (w_ack),
      .i_cfgWe      (w_cfgSel),
      .i_cfgEn      (cfg_en),
      .i_cfgLevel   (cfg_level),
      .i_cfgPc      (cfg_pc[31:2]),
      .i_cfgCount   (cfg_count),
      .o_irq        (irq[c]),
      .o_done       (done[c]),
      .o_timeoutErr (timeout_err[c])
    );
  end

  assign interrupt = |irq;

endmodule

// File: tb/tb_int_trigger_gen.sv
// Directed bench for int_trigger_gen: four channels, 4-bit counters and
// an 8-cycle watchdog. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same offset after the following edge.
module tb_int_trigger_gen;

  localparam int NCH = 4;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [31:0]    macroscopic_pc;
  logic [31:0]    m_int_addr;
  logic [3:0]     m_int_byteen;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic           cfg_en;
  logic           cfg_level;
  logic [31:0]    cfg_pc;
  logic [CW-1:0]  cfg_count;
  logic [NCH-1:0] irq;
  logic           interrupt;
  logic [NCH-1:0] done;
  logic [NCH-1:0] timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_trigger_gen #(
    .NCH      (NCH),
    .ACK_BASE (32'h0000_7f20),
    .CW       (CW),
    .TIMEOUT  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_en         (cfg_en),
    .cfg_level      (cfg_level),
    .cfg_pc         (cfg_pc),
    .cfg_count      (cfg_count),
    .irq            (irq),
    .interrupt      (interrupt),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive PC plus an optional store for one cycle; byteen 0 means no store.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be);
    macroscopic_pc = pc;
    m_int_addr     = addr;
    m_int_byteen   = be;
    tick();
    m_int_byteen   = 4'h0;
  endtask

  task automatic configChannel(input logic [2:0] ch, input logic en, input logic level,
                               input logic [31:0] pc, input logic [CW-1:0] cnt);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_en    = en;
    cfg_level = level;
    cfg_pc    = pc;
    cfg_count = cnt;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    macroscopic_pc = 32'h0000_3000;
    m_int_addr     = 32'h0;
    m_int_byteen   = 4'h0;
    cfg_we         = 1'b0;
    cfg_ch         = 3'd0;
    cfg_en         = 1'b0;
    cfg_level      = 1'b0;
    cfg_pc         = 32'h0;
    cfg_count      = '0;
    tick(2);
    reset = 1'b0;
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_int", 32'(interrupt), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_err", 32'(timeout_err), 32'h0);

    // Single level fire, count 1
    configChannel(3'd0, 1'b1, 1'b1, 32'h3010, 4'd1);
    checkOutput("t1_armed_irq", 32'(irq), 32'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t1_fire_irq", 32'(irq), 32'h1);
    checkOutput("t1_fire_int", 32'(interrupt), 32'h1);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t1_hold_irq", 32'(irq), 32'h1);
    applyStimulus(32'h3010, 32'h7f20, 4'hf);
    checkOutput("t1_ack_irq", 32'(irq), 32'h0);
    checkOutput("t1_ack_done", 32'(done), 32'h1);
    applyStimulus(32'h3014, 32'h0, 4'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t1_nofire_irq", 32'(irq), 32'h0);

    // Rearm guard with unlimited count
    applyStimulus(32'h3000, 32'h0, 4'h0);
    configChannel(3'd0, 1'b1, 1'b1, 32'h3010, 4'd0);
    checkOutput("t2_cfg_done", 32'(done), 32'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t2_fire1", 32'(irq), 32'h1);
    applyStimulus(32'h3010, 32'h7f20, 4'hf);
    checkOutput("t2_ack", 32'(irq), 32'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t2_guard_hold", 32'(irq), 32'h0);
    applyStimulus(32'h3014, 32'h0, 4'h0);
    checkOutput("t2_away", 32'(irq), 32'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t2_fire2", 32'(irq), 32'h1);
    checkOutput("t2_unlim_done", 32'(done), 32'h0);
    applyStimulus(32'h3010, 32'h7f20, 4'h2);
    checkOutput("t2_ack2", 32'(irq), 32'h0);

    // Pulse ch1 (count 2) and level ch2 on the same PC
    configChannel(3'd1, 1'b1, 1'b0, 32'h3020, 4'd2);
    configChannel(3'd2, 1'b1, 1'b1, 32'h3020, 4'd0);
    applyStimulus(32'h3020, 32'h0, 4'h0);
    checkOutput("t3_both_irq", 32'(irq), 32'h6);
    checkOutput("t3_both_int", 32'(interrupt), 32'h1);
    applyStimulus(32'h3020, 32'h0, 4'h0);
    checkOutput("t3_pulse_end", 32'(irq), 32'h4);
    checkOutput("t3_int_held", 32'(interrupt), 32'h1);
    applyStimulus(32'h3020, 32'h7f24, 4'hf);
    checkOutput("t3_idle_ack", 32'(irq), 32'h4);
    applyStimulus(32'h3020, 32'h7f2b, 4'h1);
    checkOutput("t3_ack_ch2", 32'(irq), 32'h0);
    checkOutput("t3_ack_int", 32'(interrupt), 32'h0);
    checkOutput("t3_done_none", 32'(done), 32'h0);
    applyStimulus(32'h3000, 32'h0, 4'h0);
    applyStimulus(32'h3020, 32'h0, 4'h0);
    checkOutput("t3_refire", 32'(irq), 32'h6);
    applyStimulus(32'h3020, 32'h0, 4'h0);
    checkOutput("t3_exhaust_irq", 32'(irq), 32'h4);
    checkOutput("t3_exhaust_done", 32'(done), 32'h2);
    applyStimulus(32'h3020, 32'h7f28, 4'hf);
    applyStimulus(32'h3000, 32'h0, 4'h0);
    checkOutput("t3_clear", 32'(irq), 32'h0);

    // Watchdog on ch3, then ack coinciding with expiry
    configChannel(3'd3, 1'b1, 1'b1, 32'h3030, 4'd0);
    applyStimulus(32'h3030, 32'h0, 4'h0);
    checkOutput("t4_fire", 32'(irq), 32'h8);
    tick(7);
    checkOutput("t4_before_irq", 32'(irq), 32'h8);
    checkOutput("t4_before_err", 32'(timeout_err), 32'h0);
    tick();
    checkOutput("t4_expire_irq", 32'(irq), 32'h0);
    checkOutput("t4_expire_err", 32'(timeout_err), 32'h8);
    checkOutput("t4_expire_done", 32'(done), 32'ha);
    configChannel(3'd3, 1'b1, 1'b1, 32'h3030, 4'd0);
    checkOutput("t4_cfg_err", 32'(timeout_err), 32'h0);
    tick();
    checkOutput("t4_fire2", 32'(irq), 32'h8);
    tick(7);
    applyStimulus(32'h3030, 32'h7f2c, 4'hf);
    checkOutput("t4_race_irq", 32'(irq), 32'h0);
    checkOutput("t4_race_err", 32'(timeout_err), 32'h0);
    checkOutput("t4_race_done", 32'(done), 32'h2);
    tick();
    checkOutput("t4_race_guard", 32'(irq), 32'h0);
    applyStimulus(32'h3000, 32'h0, 4'h0);

    // Config preemption mid-assertion, then reset mid-assertion
    applyStimulus(32'h3020, 32'h0, 4'h0);
    checkOutput("t5_fire", 32'(irq), 32'h4);
    configChannel(3'd2, 1'b1, 1'b1, 32'h3040, 4'd0);
    checkOutput("t5_preempt", 32'(irq), 32'h0);
    tick();
    checkOutput("t5_old_pc", 32'(irq), 32'h0);
    applyStimulus(32'h3040, 32'h0, 4'h0);
    checkOutput("t5_new_pc", 32'(irq), 32'h4);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t5_two_ch", 32'(irq), 32'h5);
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_irq", 32'(irq), 32'h0);
    checkOutput("t5_rst_int", 32'(interrupt), 32'h0);
    checkOutput("t5_rst_done", 32'(done), 32'h0);
    checkOutput("t5_rst_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    applyStimulus(32'h3010, 32'h0, 4'h0);
    applyStimulus(32'h3010, 32'h0, 4'h0);
    checkOutput("t5_cfg_lost", 32'(irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
